// File: rtl/shifter8_seq.sv
// shifter8_seq: multi-cycle shift unit that shifts a loaded operand by one bit
// per clock. It generates the shared 2-bit select for the per-bit 4:1 mux row
// and registers the row output back into the operand each SHIFT cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (highest priority)
//   start  in   request pulse, sampled only in IDLE
//   op     in   [1:0] 00 hold, 01 LSL, 10 LSR, 11 ASR
//   amt    in   [AMT_W-1:0] shift count
//   d_in   in   [WIDTH-1:0] operand, captured with start
//   q      out  [WIDTH-1:0] operand register / result
//   busy   out  high whenever not IDLE
//   done   out  one-cycle pulse, result valid on q
//
// state  | meaning
// IDLE   | waiting for start, q holds last result
// SHIFT  | one shift per edge until the count runs out
// DONE   | result valid, done pulse, back to IDLE next edge
module shifter8_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    logic [WIDTH-1:0] lsl_v, lsr_v, asr_v, row_y;

    // Per-bit mux inputs, expressed as whole vectors so the edge bits need no
    // out-of-range indexing: d1 = q[i-1] (0 at bit 0), d2 = q[i+1] (0 at MSB),
    // d3 = q[i+1] (sign at MSB).
    assign lsl_v = {q_q[WIDTH-2:0], 1'b0};
    assign lsr_v = {1'b0, q_q[WIDTH-1:1]};
    assign asr_v = {q_q[WIDTH-1], q_q[WIDTH-1:1]};

    // The mx4 row: WIDTH 4:1 muxes sharing the latched select op_q.
    always_comb begin
        row_y = q_q;
        case (op_q)
            2'b00: row_y = q_q;
            2'b01: row_y = lsl_v;
            2'b10: row_y = lsr_v;
            2'b11: row_y = asr_v;
            default: row_y = q_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d   = d_in;
                    cnt_d = amt;
                    op_d  = op;
                    // Nothing to shift: skip straight to the done pulse.
                    if ((amt == '0) || (op == 2'b00)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                q_d   = row_y;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign q    = q_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shifter8_seq.sv
module tb_shifter8_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] d_in;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int n_chk;
    int n_err;
    int done_cnt;
    logic [7:0] exp_q[$];

    shifter8_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .amt   (amt),
        .d_in  (d_in),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] o, input logic [2:0] a);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++) begin
            case (o)
                2'b01: r = r << 1;
                2'b10: r = r >> 1;
                2'b11: r = 8'($signed(r) >>> 1);
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // Scoreboard side: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("sb_result", {24'd0, q}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive a start pulse at E0; optionally push the expected result.
    task automatic launch(input logic [7:0] d, input logic [1:0] o, input logic [2:0] a, input bit push);
        d_in  = d;
        op    = o;
        amt   = a;
        start = 1'b1;
        if (push) exp_q.push_back(model(d, o, a));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done; scramble inputs meanwhile to show they
    // are latched. Bounded so a stuck FSM still reaches the summary.
    task automatic wait_done(output int n, output int b);
        n = 0;
        b = busy ? 1 : 0;
        while (!done && n < 20) begin
            d_in = 8'($urandom);
            op   = 2'($urandom);
            amt  = 3'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (busy) b++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] d, input logic [1:0] o, input logic [2:0] a);
        int n, b, lat;
        logic [7:0] e;
        e   = model(d, o, a);
        lat = (a == 3'd0 || o == 2'b00) ? 0 : int'(a);
        launch(d, o, a, 1'b1);
        wait_done(n, b);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy_cycles"}, b, lat + 1);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, {24'd0, q}, {24'd0, e});
    endtask

    initial begin
        int n, b, dc;
        n_chk = 0;
        n_err = 0;
        done_cnt = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        amt   = 3'd0;
        d_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_q", {24'd0, q}, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("idle_no_start", {30'd0, busy, done}, 32'd0);

        run_op("lsl3", 8'b1001_0110, 2'b01, 3'd3);
        chk("lsl3_value", {24'd0, q}, {24'd0, 8'b1011_0000});
        run_op("lsr3", 8'b1001_0110, 2'b10, 3'd3);
        chk("lsr3_value", {24'd0, q}, {24'd0, 8'b0001_0010});
        run_op("asr3", 8'b1001_0110, 2'b11, 3'd3);
        chk("asr3_value", {24'd0, q}, {24'd0, 8'b1111_0010});
        run_op("asr7", 8'h80, 2'b11, 3'd7);
        chk("asr7_value", {24'd0, q}, 32'hFF);
        run_op("lsl7", 8'hFF, 2'b01, 3'd7);
        run_op("lsr7", 8'hFF, 2'b10, 3'd7);
        run_op("amt0", 8'h5A, 2'b01, 3'd0);
        run_op("nop", 8'hA5, 2'b00, 3'd6);
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 8'($urandom), 2'($urandom), 3'($urandom));
        end

        // Start while busy must be ignored.
        dc = done_cnt;
        launch(8'hC3, 2'b01, 3'd5, 1'b1);
        @(posedge clk);
        #1;
        launch(8'h01, 2'b10, 3'd1, 1'b0);
        wait_done(n, b);
        chk("ign_lat", n, 3);
        repeat (6) @(posedge clk);
        #1;
        chk("ign_one_done", done_cnt - dc, 1);
        chk("ign_result", {24'd0, q}, {24'd0, model(8'hC3, 2'b01, 3'd5)});

        // Reset mid-SHIFT aborts without a done pulse.
        dc = done_cnt;
        launch(8'h3C, 2'b10, 3'd5, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("abort_q", {24'd0, q}, 32'd0);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc, 0);
        run_op("after_abort", 8'h3C, 2'b10, 3'd5);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
